// File: rtl/div_nr_32.sv
// div_nr_32: multi-cycle signed non-restoring divider (LO=quotient, HI=remainder); optional DIV_UNSIGNED_SEL_EN adds is_unsigned
module div_nr_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef DIV_UNSIGNED_SEL_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] a, a_sh, a_run, a_fix;
  logic [WIDTH-1:0] q, m, ra_mag, rb_mag;
  logic [CNT_W-1:0] cnt;
  logic sign_q, sign_r, dz_pend, uns, accept, rb_zero, last;
`ifdef DIV_UNSIGNED_SEL_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif
  assign busy = state != IDLE;
  // operand magnitudes, one add/subtract step, final remainder restore and FSM next state
  always_comb begin
    rb_zero  = RB == '0;
    accept   = state == IDLE && start && !dz_pend;
    ra_mag   = (uns || !RA[WIDTH-1]) ? RA : -RA;
    rb_mag   = (uns || !RB[WIDTH-1]) ? RB : -RB;
    a_sh     = {a[WIDTH-1:0], q[WIDTH-1]};
    a_run    = a[WIDTH] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
    a_fix    = a[WIDTH] ? a + {1'b0, m} : a;
    last     = cnt == CNT_W'(WIDTH - 1);
    state_nx = state == IDLE ? ((accept && !rb_zero) ? RUN : IDLE)
             : state == RUN  ? (last ? FIX : RUN)
             : IDLE;
  end
  // state register; clear abandons any division in flight
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= IDLE;
    else state <= state_nx;
  // datapath: latch operands, iterate, then sign-correct into LO/HI; divide-by-zero answers one edge after the start
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      a        <= '0;
      q        <= '0;
      m        <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz_pend  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      LO       <= '0;
      HI       <= '0;
    end else begin
      done    <= 1'b0;
      dz_pend <= 1'b0;
      if (accept) begin
        div_zero <= 1'b0;
        q        <= rb_zero ? RA : ra_mag;
        m        <= rb_mag;
        a        <= '0;
        cnt      <= '0;
        sign_q   <= !uns && (RA[WIDTH-1] ^ RB[WIDTH-1]);
        sign_r   <= !uns && RA[WIDTH-1];
        dz_pend  <= rb_zero;
      end
      if (dz_pend) begin
        LO       <= '1;
        HI       <= q;
        div_zero <= 1'b1;
        done     <= 1'b1;
      end
      if (state == RUN) begin
        a   <= a_run;
        q   <= {q[WIDTH-2:0], ~a_run[WIDTH]};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        a    <= a_fix;
        LO   <= sign_q ? -q : q;
        HI   <= sign_r ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_div_nr_32.sv
// tb_div_nr_32: directed self-checking bench for div_nr_32
module tb_div_nr_32;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic start = 1'b0;
  logic [31:0] RA = '0;
  logic [31:0] RB = '0;
  logic busy, done, div_zero;
  logic [31:0] LO, HI;
  int n_ch = 0;
  int n_fail = 0;
  int n;
  int seen;

  div_nr_32 dut (
    .clock(clock),
    .clear(clear),
    .start(start),
`ifdef DIV_UNSIGNED_SEL_EN
    .is_unsigned(1'b0),
`endif
    .RA(RA),
    .RB(RB),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .LO(LO),
    .HI(HI)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_ch++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ra, input logic [31:0] rb,
                     input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat);
    int c;
    @(negedge clock);
    RA = ra;
    RB = rb;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk({tag, "_busy"}, busy, exp_lat > 1);
    if (exp_lat > 1) chk({tag, "_dz_cleared"}, div_zero, 0);
    wait_done(c);
    chk({tag, "_latency"}, c, exp_lat);
    chk({tag, "_lo"}, LO, exp_lo);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_div_zero"}, div_zero, exp_lat == 1);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_lo", LO, 0);
    chk("rst_hi", HI, 0);
    @(negedge clock);
    clear = 1'b0;
    run("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run("m100_7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33);
    run("p100_m7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 33);
    run("m7_100", 32'hFFFFFFF9, 32'd100, 32'd0, 32'hFFFFFFF9, 33);
    run("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
    run("min_2", 32'h80000000, 32'd2, 32'hC0000000, 32'd0, 33);
    run("max_1", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 33);
    run("divz", 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1);
    run("after_dz", 32'd1000, 32'd33, 32'd30, 32'd10, 33);
    // start while busy is ignored, then a back-to-back start in the done cycle
    @(negedge clock);
    RA = 32'd100;
    RB = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    RA = 32'd9;
    RB = 32'd3;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(n);
    chk("ign_latency", n, 23);
    chk("ign_lo", LO, 32'd14);
    chk("ign_hi", HI, 32'd2);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    chk("b2b_done_drop", done, 0);
    chk("b2b_busy", busy, 1);
    wait_done(n);
    chk("b2b_latency", n, 33);
    chk("b2b_lo", LO, 32'd3);
    chk("b2b_hi", HI, 32'd0);
    run("divz2", 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1);
    // clear mid-operation discards the division
    @(negedge clock);
    RA = 32'd100;
    RB = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (15) @(posedge clock);
    #1 clear = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_dz", div_zero, 0);
    chk("clr_lo", LO, 0);
    chk("clr_hi", HI, 0);
    @(negedge clock);
    clear = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    chk("clr_no_done", seen, 0);
    run("p50_5", 32'd50, 32'd5, 32'd10, 32'd0, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_ch, n_fail);
    $finish;
  end
endmodule
